// File: rtl/parking_slot_manager.sv
// Parking lot slot allocator: grants the lowest free slot on entry, frees a named slot on exit,
// and holds the barrier open for DOOR_HOLD cycles after each accepted event.
module parking_slot_manager #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned DOOR_HOLD = 4,
  localparam int unsigned SW = ($clog2(NUM_SLOTS) > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req_i,
  input  logic                 exit_req_i,
  input  logic [SW-1:0]        exit_slot_i,
  output logic                 door_open_o,
  output logic                 full_o,
  output logic [NUM_SLOTS-1:0] occupancy_o,
  output logic [CW-1:0]        free_count_o,
  output logic [SW-1:0]        best_slot_o,
  output logic                 entry_ack_o,
  output logic                 exit_ack_o,
  output logic [SW-1:0]        assigned_slot_o,
  output logic                 entry_reject_o,
  output logic                 exit_err_o
);

  localparam logic [7:0] HoldLoad = 8'(DOOR_HOLD - 1);

  typedef enum logic {StIdle, StDoor} state_e;

  state_e               state_q, state_d;
  logic [7:0]           door_cnt_q, door_cnt_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [SW-1:0]        assigned_q, assigned_d;
  logic                 entry_ack_q, entry_ack_d;
  logic                 exit_ack_q, exit_ack_d;
  logic                 entry_reject_q, entry_reject_d;
  logic                 exit_err_q, exit_err_d;

  logic [CW-1:0]        free_count;
  logic [SW-1:0]        best_slot;
  logic                 full;
  logic [NUM_SLOTS-1:0] exit_mask;
  logic                 exit_valid;

  // Downward scan so the last assignment lands on the lowest free index.
  always_comb begin
    free_count = '0;
    best_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_count = free_count + CW'(1);
        best_slot  = SW'(i);
      end
    end
  end

  assign full = (free_count == '0);

  // Out-of-range indices match no bit, so they fall out as invalid exits.
  always_comb begin
    exit_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (exit_slot_i == SW'(i)) exit_mask[i] = 1'b1;
    end
  end

  assign exit_valid = |(exit_mask & occ_q);

  always_comb begin
    state_d        = state_q;
    door_cnt_d     = door_cnt_q;
    occ_d          = occ_q;
    assigned_d     = assigned_q;
    entry_ack_d    = 1'b0;
    exit_ack_d     = 1'b0;
    entry_reject_d = 1'b0;
    exit_err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (exit_req_i) begin
          if (exit_valid) begin
            occ_d      = occ_q & ~exit_mask;
            exit_ack_d = 1'b1;
            state_d    = StDoor;
            door_cnt_d = HoldLoad;
          end else begin
            exit_err_d = 1'b1;
          end
        end else if (entry_req_i) begin
          if (full) begin
            entry_reject_d = 1'b1;
          end else begin
            occ_d[best_slot] = 1'b1;
            assigned_d       = best_slot;
            entry_ack_d      = 1'b1;
            state_d          = StDoor;
            door_cnt_d       = HoldLoad;
          end
        end
      end
      StDoor: begin
        if (door_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          door_cnt_d = door_cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      door_cnt_q     <= '0;
      occ_q          <= '0;
      assigned_q     <= '0;
      entry_ack_q    <= 1'b0;
      exit_ack_q     <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      door_cnt_q     <= door_cnt_d;
      occ_q          <= occ_d;
      assigned_q     <= assigned_d;
      entry_ack_q    <= entry_ack_d;
      exit_ack_q     <= exit_ack_d;
      entry_reject_q <= entry_reject_d;
      exit_err_q     <= exit_err_d;
    end
  end

  assign door_open_o     = (state_q == StDoor);
  assign full_o          = full;
  assign occupancy_o     = occ_q;
  assign free_count_o    = free_count;
  assign best_slot_o     = best_slot;
  assign entry_ack_o     = entry_ack_q;
  assign exit_ack_o      = exit_ack_q;
  assign assigned_slot_o = assigned_q;
  assign entry_reject_o  = entry_reject_q;
  assign exit_err_o      = exit_err_q;

endmodule

// File: doc/parking_slot_manager.md
PARKING_SLOT_MANAGER -- requirements
Module: parking_slot_manager

Interface
REQ-001 Parameter NUM_SLOTS, default 8, number of parking slots; legal range 2..64.
REQ-002 Parameter DOOR_HOLD, default 4, number of clock cycles the door stays open per accepted event; legal range 1..255.
REQ-003 Derived widths SHALL be SW = max(1, clog2(NUM_SLOTS)) and CW = clog2(NUM_SLOTS+1).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 entry_req  input  1  level; a car is waiting at the entry.
REQ-007 exit_req  input  1  level; a car is waiting at the exit.
REQ-008 exit_slot  input  SW  index of the slot being vacked, valid while exit_req is high.
REQ-009 door_open  output  1  barrier open.
REQ-010 full  output  1  high while free_count == 0.
REQ-011 occupancy  output  NUM_SLOTS  bit i high = slot i occupied.
REQ-012 free_count  output  CW  number of zero bits in occupancy.
REQ-013 best_slot  output  SW  lowest-index free slot; 0 when full.
REQ-014 entry_ack  output  1  one-cycle pulse; an entry was accepted.
REQ-015 exit_ack  output  1  one-cycle pulse; an exit was accepted.
REQ-016 assigned_slot  output  SW  slot granted by the last accepted entry; held until the next accepted entry.
REQ-017 entry_reject  output  1  one-cycle pulse; an entry was refused because the lot is full.
REQ-018 exit_err  output  1  one-cycle pulse; an exit named a free or out-of-range slot.

Function
REQ-019 The FSM SHALL have two states: IDLE and DOOR. It SHALL also hold a DOOR_HOLD-range down-counter door_cnt.
REQ-020 Requests SHALL be sampled only on a rising edge while the state is IDLE; requests present in DOOR SHALL be ignored and SHALL NOT be queued.
REQ-021 In IDLE with exit_req high, exit SHALL take priority and entry_req SHALL be ignored that edge.
REQ-022 An exit is valid when exit_slot < NUM_SLOTS and occupancy[exit_slot] == 1.
REQ-023 On a valid exit, the block SHALL clear occupancy[exit_slot] and pulse exit_ack.
REQ-024 On an invalid exit, the block SHALL pulse exit_err, leave occupancy unchanged and remain in IDLE.
REQ-025 In IDLE with only entry_req high and full == 0, the block SHALL:
- set occupancy[best_slot];
- load assigned_slot with best_slot;
- pulse entry_ack.
REQ-026 In IDLE with only entry_req high and full == 1, the block SHALL pulse entry_reject, leave occupancy unchanged and remain in IDLE.
REQ-027 On an accepted entry or valid exit at edge k:
- the state SHALL go to DOOR and door_cnt SHALL load DOOR_HOLD-1;
- the ack pulse SHALL be high in the cycle following edge k.
REQ-028 In DOOR, each edge SHALL decrement door_cnt; an edge with door_cnt == 0 SHALL return the state to IDLE.
REQ-029 door_open SHALL equal (state == DOOR). It is high for exactly DOOR_HOLD cycles after edge k, and the next request can be accepted at edge k+DOOR_HOLD+1.
REQ-030 free_count, best_slot and full SHALL be combinational functions of the occupancy register. They update in the same cycle occupancy changes, with no extra latency.
REQ-031 All ack, reject and err pulses SHALL be exactly one cycle wide; a request held high SHALL produce one pulse per IDLE sample.
REQ-032 A held entry_req while full SHALL pulse entry_reject on every IDLE edge; a held invalid exit SHALL likewise pulse exit_err every edge.
REQ-033 At most one occupancy bit SHALL change per edge.
REQ-034 free_count SHALL never underflow or exceed NUM_SLOTS.

Reset
REQ-035 While reset is high, the block SHALL hold the following, independent of clk:
- state = IDLE, door_cnt = 0;
- occupancy = 0, assigned_slot = 0;
- door_open, entry_ack, exit_ack, entry_reject and exit_err = 0.
These give free_count = NUM_SLOTS, best_slot = 0 and full = 0.
REQ-036 Reset asserted mid-DOOR SHALL close the door immediately and discard the remaining hold. The first edge after deassertion SHALL sample requests in IDLE.

Verification
REQ-037 Fill (NUM_SLOTS=8, DOOR_HOLD=4): eight entries pulse entry_ack with assigned_slot = 0..7. door_open is high for 4 cycles each. The run ends with occupancy = 8'hFF, free_count = 0, full = 1.
REQ-038 Full lot, entry_req for one IDLE edge -> entry_reject pulses once, door_open stays 0, occupancy stays 8'hFF.
REQ-039 Occupancy 8'h0F, exit_slot=2 -> exit_ack pulses and occupancy = 8'h0B. The next entry gets assigned_slot = 2 (lowest free).
REQ-040 Occupancy 8'h01, exit_slot=5 -> exit_err pulses, door_open stays 0, occupancy unchanged.
REQ-041 Run with NUM_SLOTS=5 and exit_slot=6 -> exit_err pulses.
REQ-042 Run with entry_req and exit_req high together in IDLE -> only the exit is processed. Then assert reset two cycles into DOOR -> door_open drops immediately and occupancy = 0.
